// File: rtl/npc_pkg.sv
// Shared NPC core definitions used by the writeback arbiter.
// Holds default widths, the writeback request bundle and the x0 index.
package npc_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int AW_DEFAULT   = 5;

    // Architectural zero register; writes to it retire without effect.
    localparam int X0 = 0;

    typedef struct packed {
        logic [AW_DEFAULT-1:0]   addr;
        logic [XLEN_DEFAULT-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first valid bit at or above ptr, wrapping.
// Ports: valid/ptr in; one-hot grant, encoded idx and any-grant flag out.
module rr_picker #(
    parameter int NREQ = 3,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] valid,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [PW-1:0]   idx,
    output logic            any
);

    int j;

    // Walk from the farthest slot back toward ptr so the last hit,
    // i.e. the one closest to ptr, is the one that sticks.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % NREQ;
            if (valid[j]) begin
                grant    = '0;
                grant[j] = 1'b1;
                idx      = PW'(j);
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter sharing the register-file write port among writeback
// sources; one grant per cycle, registered write presented the next cycle.
// Ports: clk, rst (async, active-high), req_valid/addr/data, req_ready,
// hold, rf_wen/rf_waddr/rf_wdata, busy.
// Optional WB_ARB_BYPASS_EN adds rs1_addr/rs2_addr, rs1_hit/rs2_hit, byp_data
// for forwarding the write retiring this cycle to decode.
module wb_port_arbiter
    import npc_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int XLEN = XLEN_DEFAULT,
    parameter int AW   = AW_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*XLEN-1:0] req_data,
    output logic [NREQ-1:0]      req_ready,
    input  logic                 hold,
    output logic                 rf_wen,
    output logic [AW-1:0]        rf_waddr,
    output logic [XLEN-1:0]      rf_wdata,
`ifdef WB_ARB_BYPASS_EN
    input  logic [AW-1:0]        rs1_addr,
    input  logic [AW-1:0]        rs2_addr,
    output logic                 rs1_hit,
    output logic                 rs2_hit,
    output logic [XLEN-1:0]      byp_data,
`endif
    output logic                 busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]   ptr;
    logic [PW-1:0]   ptr_nxt;
    logic [NREQ-1:0] cand;
    logic [NREQ-1:0] grant;
    logic [PW-1:0]   win;
    logic            gnt;
    logic [AW-1:0]   win_addr;
    logic [XLEN-1:0] win_data;

    // No grant while stalled, and none while reset is asserted so that
    // nothing handshakes into a register being held clear.
    assign cand = (hold || rst) ? '0 : req_valid;

    rr_picker #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .valid (cand),
        .ptr   (ptr),
        .grant (grant),
        .idx   (win),
        .any   (gnt)
    );

    assign req_ready = grant;
    assign busy      = (|req_valid) & ~(|grant);

    assign win_addr = req_addr[int'(win)*AW +: AW];
    assign win_data = req_data[int'(win)*XLEN +: XLEN];

    assign ptr_nxt = (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr      <= '0;
            rf_wen   <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else if (gnt) begin
            ptr      <= ptr_nxt;
            rf_wen   <= (win_addr != AW'(X0));
            rf_waddr <= win_addr;
            rf_wdata <= win_data;
        end else begin
            rf_wen   <= 1'b0;
        end
    end

`ifdef WB_ARB_BYPASS_EN
    assign rs1_hit  = rf_wen && (rf_waddr == rs1_addr);
    assign rs2_hit  = rf_wen && (rf_waddr == rs2_addr);
    assign byp_data = rf_wdata;
`else
    // No forwarding path in this build.
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: vector table, hand sequences,
// and randomized traffic against a behavioural model.
module tb_wb_port_arbiter;

    localparam int N  = 3;
    localparam int XL = 32;
    localparam int A  = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*A-1:0]  req_addr;
    logic [N*XL-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            hold;
    logic            rf_wen;
    logic [A-1:0]    rf_waddr;
    logic [XL-1:0]   rf_wdata;
    logic            busy;
`ifdef WB_ARB_BYPASS_EN
    logic [A-1:0]    rs1_addr;
    logic [A-1:0]    rs2_addr;
    logic            rs1_hit;
    logic            rs2_hit;
    logic [XL-1:0]   byp_data;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wb_port_arbiter #(.NREQ(N), .XLEN(XL), .AW(A)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .hold      (hold),
        .rf_wen    (rf_wen),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
`ifdef WB_ARB_BYPASS_EN
        .rs1_addr  (rs1_addr),
        .rs2_addr  (rs2_addr),
        .rs1_hit   (rs1_hit),
        .rs2_hit   (rs2_hit),
        .byp_data  (byp_data),
`endif
        .busy      (busy)
    );

    typedef struct {
        logic [N-1:0]    v;
        logic            h;
        logic [N*A-1:0]  a;
        logic [N*XL-1:0] d;
        logic [N-1:0]    r;
        logic            b;
        logic            w;
        logic [A-1:0]    wa;
        logic [XL-1:0]   wd;
    } vec_t;

    vec_t tbl[$];

    localparam logic [N*A-1:0]  A_STD = {5'd3, 5'd2, 5'd1};
    localparam logic [N*XL-1:0] D_STD = {32'h102, 32'h101, 32'h100};

    // Reference model state
    int            m_ptr;
    logic [A-1:0]  m_addr;
    logic [XL-1:0] m_data;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Inputs are already driven (just after a rising edge). Check the
    // combinational grant mid-cycle, then the registered write after the edge.
    task automatic cycle_check(input string name, input logic [N-1:0] r,
                               input logic b, input logic w,
                               input logic [A-1:0] wa, input logic [XL-1:0] wd);
        @(negedge clk);
        chk({name, ".ready"}, 128'(req_ready), 128'(r));
        chk({name, ".busy"}, 128'(busy), 128'(b));
        @(posedge clk);
        #1;
        chk({name, ".wen"}, 128'(rf_wen), 128'(w));
        chk({name, ".waddr"}, 128'(rf_waddr), 128'(wa));
        chk({name, ".wdata"}, 128'(rf_wdata), 128'(wd));
    endtask

    function automatic vec_t mk(logic [N-1:0] v, logic h, logic [N*A-1:0] a,
                                logic [N*XL-1:0] d, logic [N-1:0] r, logic b,
                                logic w, logic [A-1:0] wa, logic [XL-1:0] wd);
        vec_t t;
        t.v = v; t.h = h; t.a = a; t.d = d; t.r = r; t.b = b;
        t.w = w; t.wa = wa; t.wd = wd;
        return t;
    endfunction

    // Winner by the rule: first valid index scanning up from ptr, wrapping.
    function automatic int pick(logic [N-1:0] v, logic h, int p);
        if (h) return -1;
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    initial begin
        logic [N-1:0]  er;
        logic          ew;
        int            w;

        // ---- reset with random inputs
        rst       = 1'b1;
        hold      = 1'b0;
        req_valid = N'($urandom_range(1, 7));
        req_addr  = N*A'($urandom);
        req_data  = {$urandom, $urandom, $urandom};
`ifdef WB_ARB_BYPASS_EN
        rs1_addr  = '0;
        rs2_addr  = '0;
`endif
        #2;
        chk("rst.ready", 128'(req_ready), 128'(0));
        @(posedge clk);
        #1;
        chk("rst.wen", 128'(rf_wen), 128'(0));
        chk("rst.waddr", 128'(rf_waddr), 128'(0));
        chk("rst.wdata", 128'(rf_wdata), 128'(0));
        @(negedge clk);
        chk("rst.ready2", 128'(req_ready), 128'(0));
        @(posedge clk);
        #1;

        // ---- first grant after reset
        rst       = 1'b0;
        req_valid = 3'b001;
        req_addr  = {5'd0, 5'd0, 5'd5};
        req_data  = {32'h0, 32'h0, 32'hA5};
        cycle_check("first", 3'b001, 1'b0, 1'b1, 5'd5, 32'hA5);

        // ---- fresh reset, then the vector table from ptr=0
        rst = 1'b1;
        #2;
        rst = 1'b0;

        for (int i = 0; i < 2; i++) begin
            tbl.push_back(mk(3'b111, 0, A_STD, D_STD, 3'b001, 0, 1, 5'd1, 32'h100));
            tbl.push_back(mk(3'b111, 0, A_STD, D_STD, 3'b010, 0, 1, 5'd2, 32'h101));
            tbl.push_back(mk(3'b111, 0, A_STD, D_STD, 3'b100, 0, 1, 5'd3, 32'h102));
        end
        tbl.push_back(mk(3'b010, 0, {5'd3, 5'd0, 5'd1},
                         {32'h102, 32'hFFFF_FFFF, 32'h100},
                         3'b010, 0, 0, 5'd0, 32'hFFFF_FFFF));
        tbl.push_back(mk(3'b111, 0, A_STD, D_STD, 3'b100, 0, 1, 5'd3, 32'h102));
        tbl.push_back(mk(3'b001, 0, A_STD, D_STD, 3'b001, 0, 1, 5'd1, 32'h100));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(3'b110, 1, A_STD, D_STD, 3'b000, 1, 0, 5'd1, 32'h100));
        tbl.push_back(mk(3'b110, 0, A_STD, D_STD, 3'b010, 0, 1, 5'd2, 32'h101));
        tbl.push_back(mk(3'b000, 0, A_STD, D_STD, 3'b000, 0, 0, 5'd2, 32'h101));
        tbl.push_back(mk(3'b110, 0, A_STD, D_STD, 3'b100, 0, 1, 5'd3, 32'h102));

        foreach (tbl[i]) begin
            req_valid = tbl[i].v;
            hold      = tbl[i].h;
            req_addr  = tbl[i].a;
            req_data  = tbl[i].d;
            cycle_check($sformatf("vec%0d", i), tbl[i].r, tbl[i].b,
                        tbl[i].w, tbl[i].wa, tbl[i].wd);
        end

        // ---- async reset while a write to x7 is in flight
        req_valid = 3'b001;
        hold      = 1'b0;
        req_addr  = {5'd7, 5'd7, 5'd7};
        req_data  = {32'h77, 32'h77, 32'h77};
        cycle_check("x7", 3'b001, 1'b0, 1'b1, 5'd7, 32'h77);
        req_valid = 3'b000;
        #3;
        rst = 1'b1;
        #1;
        chk("arst.wen", 128'(rf_wen), 128'(0));
        chk("arst.waddr", 128'(rf_waddr), 128'(0));
        chk("arst.wdata", 128'(rf_wdata), 128'(0));
        @(posedge clk);
        #1;
        chk("arst.wen2", 128'(rf_wen), 128'(0));
        rst       = 1'b0;
        req_valid = 3'b111;
        req_addr  = A_STD;
        req_data  = D_STD;
        cycle_check("arst.ptr0", 3'b001, 1'b0, 1'b1, 5'd1, 32'h100);

        // ---- randomized traffic against the model
        m_ptr  = 1;
        m_addr = 5'd1;
        m_data = 32'h100;
        for (int c = 0; c < 400; c++) begin
            req_valid = N'($urandom_range(0, 7));
            hold      = ($urandom_range(0, 3) == 0);
            req_addr  = N*A'({$urandom, $urandom});
            if ($urandom_range(0, 3) == 0)
                req_addr[A*$urandom_range(0, 2) +: A] = '0;
            req_data  = {$urandom, $urandom, $urandom};
            w  = pick(req_valid, hold, m_ptr);
            er = '0;
            ew = 1'b0;
            if (w >= 0) begin
                er[w]  = 1'b1;
                m_addr = req_addr[w*A +: A];
                m_data = req_data[w*XL +: XL];
                ew     = (m_addr != 0);
                m_ptr  = (w + 1) % N;
            end
            cycle_check($sformatf("rnd%0d", c), er,
                        (|req_valid) && (w < 0), ew, m_addr, m_data);
        end

`ifdef WB_ARB_BYPASS_EN
        // ---- forwarding compare
        req_valid = 3'b111;
        hold      = 1'b0;
        req_addr  = {5'd9, 5'd9, 5'd9};
        req_data  = {32'h1234, 32'h1234, 32'h1234};
        rs1_addr  = 5'd9;
        rs2_addr  = 5'd3;
        @(posedge clk);
        #1;
        req_valid = 3'b000;
        #1;
        chk("byp.rs1", 128'(rs1_hit), 128'(1));
        chk("byp.rs2", 128'(rs2_hit), 128'(0));
        chk("byp.data", 128'(byp_data), 128'(32'h1234));
        req_valid = 3'b111;
        req_addr  = '0;
        rs1_addr  = 5'd0;
        @(posedge clk);
        #1;
        req_valid = 3'b000;
        #1;
        chk("byp.x0", 128'(rs1_hit), 128'(0));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Round-robin arbiter that shares the single register-file write port between several writeback sources (ALU result, LSU load return, CSR read-out, …) in the NPC core. Each source presents a valid/ready write request. One request is granted per cycle, captured in an output register, and driven to the register file's write-enable/address/data inputs one cycle later. Writes to x0 are accepted and retired without asserting the write enable.

## Interface
Parameters:
- NREQ, 3, number of requesters (2..8)
- XLEN, 32, data width
- AW, 5, register address width

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  NREQ  per-requester write request valid
- req_addr  in  NREQ*AW  packed destination register index; requester i occupies bits [i*AW +: AW]
- req_data  in  NREQ*XLEN  packed write data; requester i occupies bits [i*XLEN +: XLEN]
- req_ready  out  NREQ  one-hot or zero grant; a handshake occurs when req_valid[i] and req_ready[i] are both high
- hold  in  1  pipeline stall; while high, no grant is issued
- rf_wen  out  1  register-file write enable
- rf_waddr  out  AW  register-file write address
- rf_wdata  out  XLEN  register-file write data
- busy  out  1  high when any req_valid bit is set but no grant is given this cycle

## Operation
- State: a round-robin pointer `ptr` (clog2(NREQ) bits) and an output register holding {rf_wen, rf_waddr, rf_wdata}.
- Grant is combinational. When hold=0, the winner is the first i with req_valid[i]=1, searching from ptr upward and wrapping modulo NREQ. req_ready[winner]=1; all other ready bits are 0.
- When hold=1 or no request is valid, req_ready is all zeros.
- On a grant to requester w:
  - ptr <= (w+1) mod NREQ.
  - The output register loads addr/data from w.
  - rf_wen <= (addr != 0).
- Without a grant: rf_wen <= 0. rf_waddr and rf_wdata hold their previous values.
- ptr changes only on a grant, so a held or idle cycle does not shift priority.
- Fairness: a continuously valid requester is granted within NREQ grant cycles.
- busy = |req_valid & ~|req_ready. busy is combinational.
- Requesters must hold addr and data stable while valid and not yet granted. The arbiter does not register its inputs.

## Timing
- Reset values: rf_wen=0, rf_waddr=0, rf_wdata=0, ptr=0. Asserting rst mid-operation immediately clears these values and drops a captured write that has not yet retired.
- Latency: a grant in cycle T produces rf_wen/rf_waddr/rf_wdata valid during cycle T+1. The register file writes at the end of T+1.
- Throughput: one write per cycle. Back-to-back grants to different or the same requesters are allowed.
- If hold rises in the same cycle as valid, there is no grant. The request must remain valid until a later cycle with hold=0.
- Only one write is in flight at a time, so no write-after-write ordering hazard arises inside the block.
- First cycle after rst deasserts: arbitration starts from ptr=0.

## Configuration
- WB_ARB_BYPASS_EN, when defined, adds these ports:
  - rs1_addr, in, AW
  - rs2_addr, in, AW
  - rs1_hit, out, 1
  - rs2_hit, out, 1
  - byp_data, out, XLEN, which mirrors rf_wdata
- rsN_hit = rf_wen && (rf_waddr == rsN_addr). This lets a decode stage forward the write retiring this cycle instead of reading stale register-file contents.
- When the macro is undefined, these ports and their logic are absent and behaviour is otherwise identical.

## Structure
- Shared package npc_pkg:
  - XLEN and AW defaults
  - typedef wb_req_t {logic [AW-1:0] addr; logic [XLEN-1:0] data;}
  - localparam X0 = 0
- One sub-module, rr_picker: NREQ-bit valid and ptr in, one-hot grant plus encoded index out, purely combinational. The top level contains ptr, the output register and the bypass compare.
- The output register and ptr use async-reset always blocks. They do not reuse the team's sync-reset register primitive.

## Test plan
- Reset: hold rst=1 with random inputs. Expect rf_wen=0, rf_waddr=0, rf_wdata=0 and req_ready=0. Release rst, then set req_valid=3'b001, addr=5, data=0xA5. Expect req_ready=001 in T, then rf_wen=1, rf_waddr=5, rf_wdata=0xA5 in T+1.
- Round-robin: hold req_valid=3'b111 for 6 cycles with hold=0. Expect the grant sequence 0,1,2,0,1,2 and rf_wen high for 6 consecutive cycles starting at T+1.
- x0 write: grant requester 1 with addr=0, data=0xFFFF_FFFF. Expect req_ready[1]=1, then rf_wen=0 in the next cycle; ptr still advances to 2.
- Hold: req_valid=3'b110 with ptr=1 and hold=1 for 3 cycles. Expect req_ready=0, busy=1 and rf_wen=0. Drop hold. Expect a grant to requester 1, not 2.
- Async reset mid-flight: grant a write to addr=7 and assert rst asynchronously mid-cycle before the next edge. Expect rf_wen to fall immediately, no write to x7, and ptr=0 afterwards.
- Bypass (macro defined): grant addr=9, data=0x1234 and set rs1_addr=9, rs2_addr=3 in T+1. Expect rs1_hit=1, rs2_hit=0, byp_data=0x1234. Repeat with addr=0 and rs1_addr=0; expect rs1_hit=0.
